// File: rtl/kamus_pkg.sv
// -----------------------------------------------------------------------------
// kamus_pkg
// Shared types for the kamus-v load/store unit: LSU operation codes, the LSU
// FSM state set, access-size encoding and small op-decoding helpers.
// -----------------------------------------------------------------------------
package kamus_pkg;

    typedef enum logic [3:0] {
        LSU_NONE,
        LB, LH, LW, LBU, LHU, LWU, LD,
        SB, SH, SW, SD
    } lsu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Doubleword ops and LWU have no meaning on a 32-bit datapath.
    function automatic lsu_op_e op_legalize(input lsu_op_e op, input int xlen);
        if ((xlen == 32) && ((op == LWU) || (op == LD) || (op == SD)))
            return LSU_NONE;
        return op;
    endfunction

    function automatic logic [1:0] op_size(input lsu_op_e op);
        case (op)
            LH, LHU, SH: return SZ_H;
            LW, LWU, SW: return SZ_W;
            LD, SD:      return SZ_D;
            default:     return SZ_B;
        endcase
    endfunction

    function automatic logic op_is_load(input lsu_op_e op);
        return (op == LB) || (op == LH) || (op == LW) || (op == LBU) ||
               (op == LHU) || (op == LWU) || (op == LD);
    endfunction

    function automatic logic op_is_store(input lsu_op_e op);
        return (op == SB) || (op == SH) || (op == SW) || (op == SD);
    endfunction

    function automatic logic op_signed(input lsu_op_e op);
        return (op == LB) || (op == LH) || (op == LW);
    endfunction

endpackage

// File: rtl/kamus_lsu_align.sv
// -----------------------------------------------------------------------------
// kamus_lsu_align
// Purely combinational lane alignment for the LSU.
//   i_op     : (legalised) LSU operation
//   i_off    : byte offset of the access within the XLEN-wide bus word
//   i_rs2    : store data from the register file
//   i_rdata  : raw read data from the data cache
//   o_be     : byte enables (size mask shifted to the offset)
//   o_wdata  : store data replicated across every lane
//   o_load   : load data shifted down and sign/zero-extended to XLEN
//   o_misal  : access not naturally aligned for its size
// -----------------------------------------------------------------------------
module kamus_lsu_align
    import kamus_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int OW = $clog2(NB)
) (
    input  lsu_op_e         i_op,
    input  logic [OW-1:0]   i_off,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_rdata,
    output logic [NB-1:0]   o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_load,
    output logic            o_misal
);

    logic [1:0]      w_sz;
    logic            w_sgn;
    logic [NB-1:0]   w_mask;
    logic [XLEN-1:0] w_shift;

    always_comb begin
        w_sz    = op_size(i_op);
        w_sgn   = op_signed(i_op);
        w_mask  = '0;
        o_wdata = i_rs2;
        o_load  = '0;
        o_misal = 1'b0;
        w_shift = i_rdata >> {i_off, 3'b000};

        case (w_sz)
            SZ_B: begin
                w_mask  = NB'(1);
                o_wdata = {NB{i_rs2[7:0]}};
                o_load  = w_sgn ? XLEN'($signed(w_shift[7:0])) : XLEN'(w_shift[7:0]);
            end
            SZ_H: begin
                w_mask  = NB'(3);
                o_wdata = {(NB/2){i_rs2[15:0]}};
                o_load  = w_sgn ? XLEN'($signed(w_shift[15:0])) : XLEN'(w_shift[15:0]);
                o_misal = i_off[0];
            end
            SZ_W: begin
                w_mask  = NB'(15);
                o_wdata = {(NB/4){i_rs2[31:0]}};
                o_load  = w_sgn ? XLEN'($signed(w_shift[31:0])) : XLEN'(w_shift[31:0]);
                o_misal = |i_off[1:0];
            end
            default: begin
                w_mask  = '1;
                o_wdata = i_rs2;
                o_load  = w_shift;
                o_misal = |i_off;
            end
        endcase

        o_be = w_mask << i_off;
    end

endmodule

// File: rtl/kamus_lsu.sv
// -----------------------------------------------------------------------------
// kamus_lsu
// Load/store unit and MEM/WB register for the kamus-v pipeline. Issues data
// cache requests over req/gnt/rvalid, stalls upstream while an access is
// outstanding, and flags misaligned accesses without issuing them.
//   clk_i, rst_i             : clock, async active-high reset
//   valid_i, lsu_op_i        : EX/MEM instruction valid and LSU operation
//   addr_i, rs2_data_i       : effective address and store data
//   regfile_wr_en_i, wb_mux_sel_i, rd_addr_i : WB controls passed through
//   stall_o                  : combinational upstream hold
//   dmem_*                   : data cache request / grant / response
//   *_memwb_o, memwb_valid_o : MEM/WB register
//   misaligned_o             : one-cycle pulse aligned with MEM/WB
// -----------------------------------------------------------------------------
module kamus_lsu
    import kamus_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    input  lsu_op_e             lsu_op_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [XLEN-1:0]     rs2_data_i,
    input  logic                regfile_wr_en_i,
    input  logic [1:0]          wb_mux_sel_i,
    input  logic [4:0]          rd_addr_i,
    output logic                stall_o,
    output logic                dmem_req_o,
    output logic                dmem_we_o,
    output logic [AW-1:0]       dmem_addr_o,
    output logic [XLEN/8-1:0]   dmem_be_o,
    output logic [XLEN-1:0]     dmem_wdata_o,
    input  logic                dmem_gnt_i,
    input  logic                dmem_rvalid_i,
    input  logic [XLEN-1:0]     dmem_rdata_i,
    output logic                memwb_valid_o,
    output logic                regfile_wr_en_memwb_o,
    output logic [XLEN-1:0]     alu_memwb_o,
    output logic [XLEN-1:0]     load_data_memwb_o,
    output logic [1:0]          wb_mux_sel_memwb_o,
    output logic [4:0]          rd_addr_memwb_o,
    output logic                misaligned_o
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    lsu_state_e      r_state;
    lsu_state_e      w_state_nxt;
    lsu_op_e         w_op;
    logic            w_ld;
    logic            w_st;
    logic            w_mem_op;
    logic            w_misal;
    logic            w_issue;
    logic            w_req;
    logic            w_done;
    logic            w_stall;
    logic [XLEN-1:0] w_load;

    logic            r_valid;
    logic            r_wr_en;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_load;
    logic [1:0]      r_wb_sel;
    logic [4:0]      r_rd;
    logic            r_misal;

    assign w_op     = op_legalize(lsu_op_i, XLEN);
    assign w_ld     = op_is_load(w_op);
    assign w_st     = op_is_store(w_op);
    assign w_mem_op = valid_i & (w_ld | w_st);
    assign w_issue  = w_mem_op & ~w_misal;

    kamus_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_op    (w_op),
        .i_off   (addr_i[OW-1:0]),
        .i_rs2   (rs2_data_i),
        .i_rdata (dmem_rdata_i),
        .o_be    (dmem_be_o),
        .o_wdata (dmem_wdata_o),
        .o_load  (w_load),
        .o_misal (w_misal)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_issue) begin
                    if (!dmem_gnt_i) w_state_nxt = REQ;
                    else if (w_ld)   w_state_nxt = RESP;
                end
            end
            REQ:     if (dmem_gnt_i)    w_state_nxt = w_ld ? RESP : IDLE;
            RESP:    if (dmem_rvalid_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request/done decode; rvalid only matters in RESP, gnt only while requesting.
    always_comb begin
        w_req  = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            IDLE:    w_req  = w_issue;
            REQ:     w_req  = 1'b1;
            RESP:    w_done = dmem_rvalid_i;
            default: ;
        endcase
        if (w_req && w_st && dmem_gnt_i) w_done = 1'b1;
        w_stall = w_mem_op & ~w_misal & ~w_done;
    end

    assign dmem_req_o  = w_req & ~rst_i;
    assign dmem_we_o   = w_st & dmem_req_o;
    assign stall_o     = w_stall & ~rst_i;
    assign dmem_addr_o = {addr_i[AW-1:OW], {OW{1'b0}}};

    // When not stalled the op is either non-mem, misaligned or completing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid  <= 1'b0;
            r_wr_en  <= 1'b0;
            r_alu    <= '0;
            r_load   <= '0;
            r_wb_sel <= '0;
            r_rd     <= '0;
            r_misal  <= 1'b0;
        end else begin
            r_misal <= 1'b0;
            if (w_stall) begin
                r_valid <= 1'b0;
                r_wr_en <= 1'b0;
            end else begin
                r_valid  <= valid_i;
                r_wr_en  <= regfile_wr_en_i;
                r_alu    <= XLEN'(addr_i);
                r_wb_sel <= wb_mux_sel_i;
                r_rd     <= rd_addr_i;
                r_load   <= '0;
                if (w_mem_op && w_misal) begin
                    r_wr_en <= 1'b0;
                    r_misal <= 1'b1;
                end else if (w_done && w_ld) begin
                    r_load <= w_load;
                end
            end
        end
    end

    assign memwb_valid_o         = r_valid;
    assign regfile_wr_en_memwb_o = r_wr_en;
    assign alu_memwb_o           = r_alu;
    assign load_data_memwb_o     = r_load;
    assign wb_mux_sel_memwb_o    = r_wb_sel;
    assign rd_addr_memwb_o       = r_rd;
    assign misaligned_o          = r_misal;

endmodule

// File: tb/tb_kamus_lsu.sv
// -----------------------------------------------------------------------------
// tb_kamus_lsu
// Drives a 32-bit and a 64-bit kamus_lsu from shared stimulus (sel picks the
// active one) and checks them against a byte-level model of the LSU rules.
// -----------------------------------------------------------------------------
module tb_kamus_lsu;
    import kamus_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        valid = 1'b0;
    lsu_op_e     op_s = LSU_NONE;
    logic [31:0] addr = '0;
    logic [63:0] rs2 = '0;
    logic [63:0] rdata = '0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wbsel = '0;
    logic [4:0]  rd = '0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic        stall32, req32, we32, mwv32, mwwe32, mis32;
    logic [31:0] addr32, wd32, alu32, ld32;
    logic [3:0]  be32;
    logic [1:0]  wbs32;
    logic [4:0]  rd32;

    logic        stall64, req64, we64, mwv64, mwwe64, mis64;
    logic [31:0] addr64;
    logic [63:0] wd64, alu64, ld64;
    logic [7:0]  be64;
    logic [1:0]  wbs64;
    logic [4:0]  rd64;

    always #5 clk = ~clk;

    kamus_lsu #(.XLEN(32), .AW(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid & ~sel), .lsu_op_i(op_s),
        .addr_i(addr), .rs2_data_i(rs2[31:0]), .regfile_wr_en_i(wr_en),
        .wb_mux_sel_i(wbsel), .rd_addr_i(rd), .stall_o(stall32),
        .dmem_req_o(req32), .dmem_we_o(we32), .dmem_addr_o(addr32),
        .dmem_be_o(be32), .dmem_wdata_o(wd32), .dmem_gnt_i(gnt),
        .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata[31:0]),
        .memwb_valid_o(mwv32), .regfile_wr_en_memwb_o(mwwe32),
        .alu_memwb_o(alu32), .load_data_memwb_o(ld32),
        .wb_mux_sel_memwb_o(wbs32), .rd_addr_memwb_o(rd32), .misaligned_o(mis32)
    );

    kamus_lsu #(.XLEN(64), .AW(32)) u_dut64 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid & sel), .lsu_op_i(op_s),
        .addr_i(addr), .rs2_data_i(rs2), .regfile_wr_en_i(wr_en),
        .wb_mux_sel_i(wbsel), .rd_addr_i(rd), .stall_o(stall64),
        .dmem_req_o(req64), .dmem_we_o(we64), .dmem_addr_o(addr64),
        .dmem_be_o(be64), .dmem_wdata_o(wd64), .dmem_gnt_i(gnt),
        .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
        .memwb_valid_o(mwv64), .regfile_wr_en_memwb_o(mwwe64),
        .alu_memwb_o(alu64), .load_data_memwb_o(ld64),
        .wb_mux_sel_memwb_o(wbs64), .rd_addr_memwb_o(rd64), .misaligned_o(mis64)
    );

    logic        o_stall, o_req, o_we, o_mwv, o_mwwe, o_mis;
    logic [31:0] o_addr;
    logic [7:0]  o_be;
    logic [63:0] o_wd, o_alu, o_ld;
    logic [1:0]  o_wbs;
    logic [4:0]  o_rd;

    assign o_stall = sel ? stall64 : stall32;
    assign o_req   = sel ? req64   : req32;
    assign o_we    = sel ? we64    : we32;
    assign o_addr  = sel ? addr64  : addr32;
    assign o_be    = sel ? be64    : {4'b0, be32};
    assign o_wd    = sel ? wd64    : {32'b0, wd32};
    assign o_mwv   = sel ? mwv64   : mwv32;
    assign o_mwwe  = sel ? mwwe64  : mwwe32;
    assign o_alu   = sel ? alu64   : {32'b0, alu32};
    assign o_ld    = sel ? ld64    : {32'b0, ld32};
    assign o_wbs   = sel ? wbs64   : wbs32;
    assign o_rd    = sel ? rd64    : rd32;
    assign o_mis   = sel ? mis64   : mis32;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned sz_bytes(input lsu_op_e op);
        case (op)
            LB, LBU, SB:      return 1;
            LH, LHU, SH:      return 2;
            LW, LWU, SW:      return 4;
            LD, SD:           return 8;
            default:          return 0;
        endcase
    endfunction

    function automatic lsu_op_e legal_op(input lsu_op_e op, input int unsigned xl);
        if (xl == 32 && (op == LWU || op == LD || op == SD)) return LSU_NONE;
        return op;
    endfunction

    // One instruction through MEM: gd = cycles before gnt, rvd = rvalid delay after gnt.
    task automatic do_access(input bit s, input bit v, input lsu_op_e op, input logic [31:0] a,
                             input logic [63:0] st_data, input logic [63:0] ld_bus,
                             input int unsigned gd, input int unsigned rvd,
                             input logic wen, input logic [4:0] rdi, input logic [1:0] wsel);
        int unsigned xl, nbw, nb, off, nst, exp_nst;
        lsu_op_e     lop;
        bit          is_ld, is_st, mem, mis, sgn;
        logic [7:0]  e_be;
        logic [63:0] e_wd, e_ld, xmask;

        xl    = s ? 64 : 32;
        nbw   = xl / 8;
        xmask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        lop   = legal_op(op, xl);
        nb    = sz_bytes(lop);
        is_ld = lop inside {LB, LH, LW, LBU, LHU, LWU, LD};
        is_st = lop inside {SB, SH, SW, SD};
        sgn   = lop inside {LB, LH, LW};
        mem   = v && (is_ld || is_st);
        mis   = mem && nb > 1 && (a % nb) != 0;
        off   = a % nbw;

        e_be = '0;
        e_wd = '0;
        e_ld = '0;
        for (int unsigned i = 0; i < nbw; i++)
            if (i >= off && i < off + nb) e_be[i] = 1'b1;
        if (nb > 0)
            for (int unsigned i = 0; i < nbw; i++)
                e_wd[8*i +: 8] = st_data[8*(i % nb) +: 8];
        for (int unsigned k = 0; k < nb; k++)
            if (off + k < 8) e_ld[8*k +: 8] = ld_bus[8*(off+k) +: 8];
        if (sgn && nb < 8 && e_ld[8*nb-1]) e_ld = e_ld | (64'hFFFF_FFFF_FFFF_FFFF << (8*nb));
        e_ld = is_ld ? (e_ld & xmask) : 64'h0;

        sel = s; valid = v; op_s = op; addr = a; rs2 = st_data; rdata = ld_bus;
        wr_en = wen; rd = rdi; wbsel = wsel; gnt = 1'b0; rvalid = 1'b0;

        if (!mem || mis) begin
            #1;
            chk("nomem_req", o_req, 0);
            chk("nomem_stall", o_stall, 0);
            step();
            chk("mw_valid", o_mwv, v);
            chk("mw_wren", o_mwwe, mis ? 1'b0 : wen);
            chk("misaligned", o_mis, mis);
            chk("mw_alu", o_alu, {32'b0, a});
            chk("mw_rd", o_rd, rdi);
            chk("mw_wbsel", o_wbs, wsel);
            if (!mis) chk("mw_load_zero", o_ld, 0);
        end else begin
            nst = 0;
            exp_nst = is_st ? gd : gd + rvd;
            for (int unsigned g = 0; g <= gd; g++) begin
                gnt = (g == gd);
                rvalid = is_ld ? 1'($urandom_range(0, 1)) : 1'b0;
                #1;
                chk("req", o_req, 1);
                chk("req_we", o_we, is_st);
                chk("req_addr", o_addr, a & ~32'(nbw - 1));
                chk("req_be", o_be, e_be);
                if (is_st) chk("req_wdata", o_wd, e_wd);
                chk("req_stall", o_stall, is_ld || g != gd);
                nst += o_stall;
                step();
                if (g != gd || is_ld) chk("bubble_req", o_mwv, 0);
            end
            gnt = 1'b0;
            rvalid = 1'b0;
            if (is_ld) begin
                for (int unsigned r = 1; r <= rvd; r++) begin
                    rvalid = (r == rvd);
                    #1;
                    chk("resp_req", o_req, 0);
                    chk("resp_stall", o_stall, r != rvd);
                    nst += o_stall;
                    step();
                    if (r != rvd) chk("bubble_resp", o_mwv, 0);
                end
            end
            rvalid = 1'b0;
            chk("stall_cycles", 64'(nst), 64'(exp_nst));
            chk("done_valid", o_mwv, 1);
            chk("done_wren", o_mwwe, wen);
            chk("done_alu", o_alu, {32'b0, a});
            chk("done_load", o_ld, e_ld);
            chk("done_rd", o_rd, rdi);
            chk("done_wbsel", o_wbs, wsel);
            chk("done_misal", o_mis, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        rst = 1'b1;
        valid = 1'b1; op_s = SW; addr = 32'h104;
        #2;
        chk("rst_req", o_req, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_mwv", o_mwv, 0);
        chk("rst_wren", o_mwwe, 0);
        chk("rst_alu", o_alu, 0);
        chk("rst_load", o_ld, 0);
        chk("rst_misal", o_mis, 0);
        valid = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Directed cases, issued back to back.
        do_access(0, 1, SW,  32'h104,  64'hDEADBEEF, 64'h0, 0, 1, 1'b0, 5'd0,  2'd0);
        do_access(0, 1, SB,  32'h103,  64'h000000A5, 64'h0, 2, 1, 1'b0, 5'd0,  2'd0);
        do_access(0, 1, LH,  32'h202,  64'h0, 64'h80010000, 0, 3, 1'b1, 5'd7,  2'd1);
        do_access(0, 1, LHU, 32'h202,  64'h0, 64'h80010000, 0, 3, 1'b1, 5'd8,  2'd1);
        do_access(0, 1, LW,  32'h102,  64'h0, 64'h0,        0, 1, 1'b1, 5'd9,  2'd1);
        do_access(0, 1, LD,  32'h100,  64'h0, 64'h12345678, 0, 1, 1'b1, 5'd10, 2'd2);
        do_access(0, 0, LW,  32'h100,  64'h0, 64'h12345678, 0, 1, 1'b1, 5'd11, 2'd3);
        do_access(0, 1, LB,  32'h3,    64'h0, 64'h80000000, 1, 1, 1'b1, 5'd12, 2'd1);
        do_access(1, 1, LWU, 32'h1004, 64'h0, 64'hF0000000_00000000, 0, 1, 1'b1, 5'd13, 2'd1);
        do_access(1, 1, SD,  32'h1008, 64'h01234567_89ABCDEF, 64'h0, 1, 1, 1'b0, 5'd0, 2'd0);
        do_access(1, 1, LD,  32'h1004, 64'h0, 64'h0, 0, 1, 1'b1, 5'd14, 2'd1);
        do_access(1, 1, SH,  32'h1006, 64'h0000BEEF, 64'h0, 0, 1, 1'b0, 5'd0, 2'd0);
        valid = 1'b0;
        step();

        // Reset while waiting for rvalid: the late response must be dropped.
        sel = 1'b0; valid = 1'b1; op_s = LW; addr = 32'h300; wr_en = 1'b1; gnt = 1'b1;
        #1;
        step();
        gnt = 1'b0;
        #1;
        chk("resp_wait_stall", o_stall, 1);
        rst = 1'b1;
        valid = 1'b0;
        #1;
        chk("midrst_req", o_req, 0);
        chk("midrst_stall", o_stall, 0);
        chk("midrst_mwv", o_mwv, 0);
        chk("midrst_wren", o_mwwe, 0);
        chk("midrst_alu", o_alu, 0);
        chk("midrst_load", o_ld, 0);
        chk("midrst_misal", o_mis, 0);
        step();
        rst = 1'b0;
        rdata = 64'hFFFF_FFFF;
        rvalid = 1'b1;
        #1;
        chk("late_rv_req", o_req, 0);
        chk("late_rv_stall", o_stall, 0);
        step();
        rvalid = 1'b0;
        chk("late_rv_mwv", o_mwv, 0);
        chk("late_rv_load", o_ld, 0);

        // Randomised mix across both widths.
        for (int unsigned n = 0; n < 80; n++) begin
            bit          s;
            lsu_op_e     op;
            logic [31:0] a;
            int unsigned sz;
            s  = 1'($urandom_range(0, 1));
            op = lsu_op_e'(4'($urandom_range(0, 11)));
            a  = $urandom & 32'h0000_FFFF;
            sz = sz_bytes(op);
            if (sz > 0 && $urandom_range(0, 3) != 0) a = a - (a % sz);
            do_access(s, $urandom_range(0, 7) != 0, op, a, {$urandom, $urandom},
                      {$urandom, $urandom}, $urandom_range(0, 2), $urandom_range(1, 3),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                      2'($urandom_range(0, 3)));
        end
        valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kamus_lsu.md
# kamus_lsu

Parametrised load/store unit and MEM/WB register for the kamus-v pipeline, successor to the fixed single-cycle MEM stage. It sits between the EX/MEM register and WB, and talks to the L1 data cache over a req/gnt/rvalid handshake, so memory latency is variable. It asserts `stall_o` upstream while an access is outstanding. It generates byte enables and lane-replicated store data, extracts and sign/zero-extends load data by byte offset, and flags misaligned accesses.

## Interface
- `XLEN`, default 32: data width; legal values are 32 and 64.
- `AW`, default 32: address width.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset. One clock; reset is asynchronous and active-high.
- `valid_i` in 1: EX/MEM holds a valid instruction.
- `lsu_op_i` in `lsu_op_e`: LSU_NONE, LB, LH, LW, LBU, LHU, LWU, LD, SB, SH, SW, SD.
- `addr_i` in AW: ALU result, the effective address.
- `rs2_data_i` in XLEN: store data.
- `regfile_wr_en_i` in 1, `wb_mux_sel_i` in 2, `rd_addr_i` in 5: WB controls.
- `stall_o` out 1: hold EX/MEM and earlier stages. This output is combinational.
- `dmem_req_o` out 1, `dmem_we_o` out 1, `dmem_addr_o` out AW: request; the address is XLEN/8-aligned.
- `dmem_be_o` out XLEN/8, `dmem_wdata_o` out XLEN: byte enables and lane-aligned write data.
- `dmem_gnt_i` in 1: request accepted this cycle.
- `dmem_rvalid_i` in 1, `dmem_rdata_i` in XLEN: load response.
- `memwb_valid_o` out 1, `regfile_wr_en_memwb_o` out 1, `alu_memwb_o` out XLEN, `load_data_memwb_o` out XLEN, `wb_mux_sel_memwb_o` out 2, `rd_addr_memwb_o` out 5: MEM/WB register.
- `misaligned_o` out 1: registered one-cycle pulse, aligned with MEM/WB.

## Operation
- The FSM has three states: IDLE, REQ (request not yet granted) and RESP (load granted, awaiting rvalid).
- `mem_op` means `valid_i` with a load or store op.
- `misal` is set when the halfword offset is odd, the word offset is not a multiple of 4, or a D access has `addr_i[2:0]` not equal to 0.
- A LWU, LD or SD op with XLEN=32 is treated as LSU_NONE.
- IDLE:
  - Non-mem op: MEM/WB captures the inputs, `load_data` becomes 0, no stall.
  - `misal`: no request is issued. `misaligned_o` is set, `regfile_wr_en_memwb_o` is forced to 0, and `memwb_valid_o` is set to 1.
  - Otherwise `dmem_req_o` is set to 1.
  - Store with gnt: the store completes and MEM/WB captures the inputs.
  - Load with gnt: go to RESP.
  - No gnt: go to REQ.
- REQ: `dmem_req_o` stays at 1, with address, we, be and wdata driven from the held inputs.
  - On gnt, a store completes (go to IDLE) and a load goes to RESP.
- RESP: `dmem_req_o` is 0.
  - On rvalid, MEM/WB captures the extracted load data and the FSM goes to IDLE.
- `stall_o = mem_op & ~misal & ~done`, where done is store&gnt or RESP&rvalid.
- While stalled, MEM/WB takes a bubble (`memwb_valid_o`=0, `regfile_wr_en_memwb_o`=0), other fields don't care.
- Store alignment:
  - `be` is the size mask shifted left by the offset (`addr_i[$clog2(XLEN/8)-1:0]`).
  - `wdata` replicates the low byte, halfword or word of rs2 across all lanes.
- Load extraction:
  - Shift `rdata` right by offset×8, then take the low 8, 16, 32 or 64 bits.
  - LB, LH and LW sign-extend to XLEN; LBU, LHU and LWU zero-extend.
- `rvalid` in IDLE or REQ is ignored.
- Inputs are stable while `stall_o` is 1; the pipeline guarantees this.

## Timing
- On reset:
  - The FSM goes to IDLE.
  - All MEM/WB outputs and `misaligned_o` go to 0.
  - `dmem_req_o` is 0 while `rst_i` is high.
- Mid-access reset: the pending access is abandoned, and a late `rvalid` is dropped in IDLE.
- Non-mem and misaligned ops have 1-cycle latency to MEM/WB.
- A store granted in the issue cycle has 1-cycle latency with zero stall cycles.
- Each cycle without gnt adds one stall cycle.
- Loads:
  - `rvalid` comes at the earliest one cycle after gnt, so minimum stall is 1 cycle.
  - MEM/WB updates on the edge ending the rvalid cycle.
- A new `mem_op` may issue in the cycle after completion, so back-to-back accesses are possible.

## Structure
- `kamus_pkg` holds `lsu_op_e`, `lsu_state_e` and the size encoding (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`).
- Sub-module `kamus_lsu_align` is pure combinational. It takes op, offset, rs2 and rdata, and returns be, wdata, load_data and misal.
- `kamus_lsu` holds the FSM and the MEM/WB register.

## Test plan
- SW addr=0x104, rs2=0xDEADBEEF, gnt same cycle:
  - `be`=0xF, `addr`=0x104, no stall.
  - Next cycle `alu_memwb_o`=0x104 and `regfile_wr_en_memwb_o`=0.
- SB addr=0x103, rs2=0x000000A5, gnt after 2 cycles:
  - `be`=0x8, `wdata`=0xA5A5A5A5.
  - `stall_o` high for 2 cycles, req held stable.
- LH addr=0x202, rdata=0x8001_0000, rvalid 3 cycles after gnt:
  - `load_data_memwb_o`=0xFFFF8001. The same case with LHU gives 0x00008001.
  - `stall_o` high for exactly 3 cycles.
- LW addr=0x102:
  - No `dmem_req_o`, no stall.
  - `misaligned_o`=1 and `regfile_wr_en_memwb_o`=0 next cycle.
- Load in RESP, assert `rst_i` mid-wait, then rvalid:
  - All outputs 0, `dmem_req_o`=0, FSM in IDLE, rvalid ignored.
- XLEN=64, LWU addr=0x1004, rdata=0xF0000000_00000000:
  - `load_data_memwb_o`=0x00000000_F0000000.
